// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: user command/response handshake plus the control, data and status lines
// exchanged with the I2C master. The sequencer uses the master modport; the environment uses slave.
interface i2c_txn_sequencer_if;
    logic        Cmd_valid, Cmd_ready;
    logic [1:0]  Cmd_op;
    logic [7:0]  Cmd_ptr;
    logic [15:0] Cmd_wdata;
    logic        Resp_valid, Resp_ready;
    logic [15:0] Resp_data;
    logic [1:0]  Resp_code;
    logic        Start, R_W, Set_pointer, Return;
    logic [7:0]  Pointer, Wdata_msb, Wdata_lsb;
    logic        Ready, Repeat, Data_valid, Error;
    logic [7:0]  Data_rd;
    modport master (
        input  Cmd_valid, Cmd_op, Cmd_ptr, Cmd_wdata, Resp_ready,
               Ready, Repeat, Data_valid, Error, Data_rd,
        output Cmd_ready, Resp_valid, Resp_data, Resp_code,
               Start, R_W, Pointer, Set_pointer, Return, Wdata_msb, Wdata_lsb
    );
    modport slave (
        output Cmd_valid, Cmd_op, Cmd_ptr, Cmd_wdata, Resp_ready,
               Ready, Repeat, Data_valid, Error, Data_rd,
        input  Cmd_ready, Resp_valid, Resp_data, Resp_code,
               Start, R_W, Pointer, Set_pointer, Return, Wdata_msb, Wdata_lsb
    );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one register-access command at a time into Start/R_W/Pointer/
// Set_pointer/Return sequencing for the I2C master and returns one response per command.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                 Clk,
    input logic                 Rst,
    i2c_txn_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_RETURN, S_RESP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d, wmsb_q, wmsb_d, wlsb_q, wlsb_d;
    logic        rw_q, rw_d, setp_q, setp_d, start_q, start_d, ret_q, ret_d;
    logic        rd_q, rd_d, two_q, two_d, err_q, err_d, dv_q;
    logic [1:0]  cnt_q, cnt_d, code_q, code_d, need;
    logic [15:0] cap_q, cap_d, data_q, data_d, tmo_q, tmo_d;
    logic        active, capture, expired;

    assign bus.Cmd_ready   = (state_q == S_IDLE) & bus.Ready & ~Rst;
    assign bus.Resp_valid  = state_q == S_RESP;
    assign bus.Resp_data   = data_q;
    assign bus.Resp_code   = code_q;
    assign bus.Start       = start_q;
    assign bus.R_W         = rw_q;
    assign bus.Pointer     = ptr_q;
    assign bus.Set_pointer = setp_q;
    assign bus.Return      = ret_q;
    assign bus.Wdata_msb   = wmsb_q;
    assign bus.Wdata_lsb   = wlsb_q;

    assign need    = two_q ? 2'd2 : 2'd1;
    assign active  = state_q inside {S_LAUNCH, S_BUSY, S_RETURN};
    assign capture = (state_q == S_BUSY) & bus.Data_valid & ~dv_q & (cnt_q < need);
    assign expired = active & (tmo_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wmsb_d  = wmsb_q;
        wlsb_d  = wlsb_q;
        rw_d    = rw_q;
        setp_d  = setp_q;
        start_d = start_q;
        ret_d   = ret_q;
        rd_d    = rd_q;
        two_d   = two_q;
        code_d  = code_q;
        data_d  = data_q;
        tmo_d   = active ? tmo_q + 16'd1 : tmo_q;
        cap_d   = capture ? (cnt_q == 2'd0 ? {bus.Data_rd, cap_q[7:0]} : {cap_q[15:8], bus.Data_rd}) : cap_q;
        cnt_d   = capture ? cnt_q + 2'd1 : cnt_q;
        err_d   = err_q | ((state_q == S_BUSY) & bus.Error);
        // A timeout pre-empts every other decision, including a simultaneous Ready.
        if (expired) begin
            state_d = S_RESP;
            start_d = 1'b0;
            ret_d   = 1'b0;
            code_d  = 2'b11;
            data_d  = 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: if (bus.Cmd_valid & bus.Cmd_ready) begin
                    ptr_d   = bus.Cmd_ptr;
                    wmsb_d  = bus.Cmd_wdata[15:8];
                    wlsb_d  = bus.Cmd_wdata[7:0];
                    two_d   = bus.Cmd_ptr[1:0] != 2'b01;
                    rd_d    = bus.Cmd_op[1] ^ bus.Cmd_op[0];
                    rw_d    = bus.Cmd_op == 2'b10;
                    setp_d  = bus.Cmd_op == 2'b01;
                    start_d = bus.Cmd_op != 2'b11;
                    state_d = bus.Cmd_op == 2'b11 ? S_RESP : S_LAUNCH;
                    cnt_d   = 2'd0;
                    cap_d   = 16'h0000;
                    tmo_d   = 16'h0000;
                    err_d   = 1'b0;
                    code_d  = 2'b11;
                    data_d  = 16'h0000;
                end
                S_LAUNCH: if (!bus.Ready) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end
                S_BUSY: if (bus.Repeat & setp_q) begin
                    state_d = S_RETURN;
                    ret_d   = 1'b1;
                    rw_d    = 1'b1;
                    setp_d  = 1'b0;
                end else if (bus.Ready) begin
                    state_d = S_RESP;
                    code_d  = err_d ? 2'b10 : (rd_q & (cnt_d < need)) ? 2'b01 : 2'b00;
                    data_d  = !rd_q ? 16'h0000 : two_q ? cap_d : {8'h00, cap_d[15:8]};
                end
                S_RETURN: if (!bus.Repeat) begin
                    ret_d   = 1'b0;
                    state_d = S_BUSY;
                end
                S_RESP: if (bus.Resp_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wmsb_q  <= '0;
            wlsb_q  <= '0;
            rw_q    <= 1'b0;
            setp_q  <= 1'b0;
            start_q <= 1'b0;
            ret_q   <= 1'b0;
            rd_q    <= 1'b0;
            two_q   <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            cnt_q   <= '0;
            code_q  <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wmsb_q  <= wmsb_d;
            wlsb_q  <= wlsb_d;
            rw_q    <= rw_d;
            setp_q  <= setp_d;
            start_q <= start_d;
            ret_q   <= ret_d;
            rd_q    <= rd_d;
            two_q   <= two_d;
            err_q   <= err_d;
            dv_q    <= bus.Data_valid;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: scripted I2C master model driving the sequencer; expected responses are
// queued when each command is issued and compared when the response handshake completes.
module tb_i2c_txn_sequencer;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    i2c_txn_sequencer_if bus();
    i2c_txn_sequencer #(.TIMEOUT_CYCLES(16)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    typedef struct { logic [15:0] d; logic [1:0] c; bit chk_d; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] ptr, input logic [15:0] wd);
        int n = 0;
        bus.Cmd_op = op;
        bus.Cmd_ptr = ptr;
        bus.Cmd_wdata = wd;
        bus.Cmd_valid = 1'b1;
        while (!bus.Cmd_ready && n < 20) begin tick(); n++; end
        total++;
        if (bus.Cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_accept: Cmd_ready=%b required 1", bus.Cmd_ready); end
        tick();
        bus.Cmd_valid = 1'b0;
    endtask

    task automatic recv(output logic [15:0] d, output logic [1:0] c);
        int n = 0;
        bus.Resp_ready = 1'b1;
        while (!bus.Resp_valid && n < 40) begin tick(); n++; end
        d = bus.Resp_data;
        c = bus.Resp_code;
        if (bus.Resp_valid !== 1'b1) begin total++; bad++; $display("FAIL resp_wait: Resp_valid=%b required 1 within 40 cycles", bus.Resp_valid); end
        tick();
        bus.Resp_ready = 1'b0;
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        bus.Data_rd = b;
        bus.Data_valid = 1'b1;
        tick();
        bus.Data_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [47:0] o;
        bus.Ready = 1'b1;
        tick(2);
        o = {bus.Cmd_ready, bus.Resp_valid, bus.Resp_data, bus.Resp_code, bus.Start, bus.R_W, bus.Pointer,
             bus.Set_pointer, bus.Return, bus.Wdata_msb, bus.Wdata_lsb};
        total++;
        if (o !== 48'h0) begin bad++; $display("FAIL reset_outputs: got %h required 000000000000", o); end
        Rst = 1'b0;
        tick();
        total++;
        if (bus.Cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: Cmd_ready=%b required 1", bus.Cmd_ready); end
    endtask

    task automatic test_write;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'h0000, c: 2'b00, chk_d: 1'b1});
        send(2'b00, 8'h02, 16'h1234);
        total++;
        if (bus.Start !== 1'b1 || bus.Pointer !== 8'h02 || bus.Wdata_msb !== 8'h12 || bus.Wdata_lsb !== 8'h34 || bus.R_W !== 1'b0 || bus.Set_pointer !== 1'b0) begin
            bad++; $display("FAIL write_launch: Start=%b Pointer=%h msb=%h lsb=%h R_W=%b Set_pointer=%b required 1 02 12 34 0 0",
                            bus.Start, bus.Pointer, bus.Wdata_msb, bus.Wdata_lsb, bus.R_W, bus.Set_pointer);
        end
        bus.Ready = 1'b0;
        tick();
        total++;
        if (bus.Start !== 1'b0) begin bad++; $display("FAIL write_start_drop: Start=%b required 0", bus.Start); end
        tick(3);
        total++;
        if (bus.Pointer !== 8'h02 || bus.Wdata_msb !== 8'h12 || bus.Wdata_lsb !== 8'h34 || bus.Resp_valid !== 1'b0) begin
            bad++; $display("FAIL write_hold: Pointer=%h msb=%h lsb=%h Resp_valid=%b required 02 12 34 0",
                            bus.Pointer, bus.Wdata_msb, bus.Wdata_lsb, bus.Resp_valid);
        end
        bus.Ready = 1'b1;
        tick();
        total++;
        if (bus.Resp_valid !== 1'b1) begin bad++; $display("FAIL write_resp_latency: Resp_valid=%b required 1", bus.Resp_valid); end
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL write_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
        total++;
        if (bus.Resp_valid !== 1'b0 || bus.Cmd_ready !== 1'b1) begin
            bad++; $display("FAIL write_release: Resp_valid=%b Cmd_ready=%b required 0 1", bus.Resp_valid, bus.Cmd_ready);
        end
    endtask

    task automatic test_ptr_read;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'h1980, c: 2'b00, chk_d: 1'b1});
        send(2'b01, 8'h00, 16'h0000);
        bus.Ready = 1'b0;
        tick(3);
        bus.Repeat = 1'b1;
        tick();
        total++;
        if (bus.Return !== 1'b1 || bus.R_W !== 1'b1 || bus.Set_pointer !== 1'b0) begin
            bad++; $display("FAIL ptr_return_rise: Return=%b R_W=%b Set_pointer=%b required 1 1 0", bus.Return, bus.R_W, bus.Set_pointer);
        end
        tick(2);
        total++;
        if (bus.Return !== 1'b1) begin bad++; $display("FAIL ptr_return_hold: Return=%b required 1", bus.Return); end
        bus.Repeat = 1'b0;
        tick();
        total++;
        if (bus.Return !== 1'b0 || bus.R_W !== 1'b1) begin bad++; $display("FAIL ptr_return_fall: Return=%b R_W=%b required 0 1", bus.Return, bus.R_W); end
        pulse_byte(8'h19);
        pulse_byte(8'h80);
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL ptr_read_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_one_byte;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'h0060, c: 2'b00, chk_d: 1'b1});
        send(2'b10, 8'h01, 16'h0000);
        total++;
        if (bus.R_W !== 1'b1 || bus.Set_pointer !== 1'b0) begin bad++; $display("FAIL one_byte_rw: R_W=%b Set_pointer=%b required 1 0", bus.R_W, bus.Set_pointer); end
        bus.Ready = 1'b0;
        tick();
        pulse_byte(8'h60);
        pulse_byte(8'hAA);
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL one_byte_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_nack;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'h0000, c: 2'b01, chk_d: 1'b1});
        send(2'b10, 8'h00, 16'h0000);
        bus.Ready = 1'b0;
        tick(3);
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL addr_nack_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
        sb.push_back('{d: 16'h0000, c: 2'b10, chk_d: 1'b0});
        send(2'b01, 8'h00, 16'h0000);
        bus.Ready = 1'b0;
        tick();
        bus.Error = 1'b1;
        tick();
        bus.Error = 1'b0;
        tick();
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL ptr_nack_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_timeout;
        logic [15:0] d; logic [1:0] c; exp_t e;
        int k = 0;
        sb.push_back('{d: 16'h0000, c: 2'b11, chk_d: 1'b1});
        send(2'b00, 8'h05, 16'h00FF);
        bus.Ready = 1'b0;
        while (!bus.Resp_valid && k < 40) begin
            tick();
            k++;
            if (k == 15) bus.Ready = 1'b1;
        end
        total++;
        if (k != 16 || bus.Start !== 1'b0 || bus.Return !== 1'b0) begin
            bad++; $display("FAIL timeout_latency: cycles=%0d Start=%b Return=%b required 16 0 0", k, bus.Start, bus.Return);
        end
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL timeout_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_illegal;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'h0000, c: 2'b11, chk_d: 1'b1});
        send(2'b11, 8'hAA, 16'hFFFF);
        total++;
        if (bus.Resp_valid !== 1'b1 || bus.Start !== 1'b0) begin
            bad++; $display("FAIL illegal_direct: Resp_valid=%b Start=%b required 1 0", bus.Resp_valid, bus.Start);
        end
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL illegal_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d; logic [1:0] c; exp_t e;
        logic [47:0] o;
        int hits = 0;
        send(2'b10, 8'h3C, 16'hABCD);
        bus.Ready = 1'b0;
        tick();
        pulse_byte(8'h55);
        #2 Rst = 1'b1;
        #1;
        o = {bus.Cmd_ready, bus.Resp_valid, bus.Resp_data, bus.Resp_code, bus.Start, bus.R_W, bus.Pointer,
             bus.Set_pointer, bus.Return, bus.Wdata_msb, bus.Wdata_lsb};
        total++;
        if (o !== 48'h0) begin bad++; $display("FAIL mid_reset_outputs: got %h required 000000000000", o); end
        tick(2);
        bus.Ready = 1'b1;
        Rst = 1'b0;
        bus.Resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.Resp_valid) hits++;
        end
        bus.Resp_ready = 1'b0;
        total++;
        if (hits != 0) begin bad++; $display("FAIL mid_reset_no_resp: Resp_valid cycles=%0d required 0", hits); end
        sb.push_back('{d: 16'h00C3, c: 2'b00, chk_d: 1'b1});
        send(2'b10, 8'h01, 16'h0000);
        bus.Ready = 1'b0;
        tick();
        pulse_byte(8'hC3);
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL after_reset_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d; logic [1:0] c; exp_t e;
        sb.push_back('{d: 16'hA55A, c: 2'b00, chk_d: 1'b1});
        send(2'b10, 8'h02, 16'h0000);
        bus.Ready = 1'b0;
        tick();
        pulse_byte(8'hA5);
        bus.Data_rd = 8'h5A;
        bus.Data_valid = 1'b1;
        bus.Ready = 1'b1;
        tick();
        bus.Data_valid = 1'b0;
        total++;
        if (bus.Resp_valid !== 1'b1) begin bad++; $display("FAIL same_edge_resp: Resp_valid=%b required 1", bus.Resp_valid); end
        bus.Cmd_op = 2'b00;
        bus.Cmd_ptr = 8'h7E;
        bus.Cmd_wdata = 16'hBEEF;
        bus.Cmd_valid = 1'b1;
        tick(2);
        total++;
        if (bus.Cmd_ready !== 1'b0 || bus.Start !== 1'b0 || bus.Resp_valid !== 1'b1) begin
            bad++; $display("FAIL resp_holdoff: Cmd_ready=%b Start=%b Resp_valid=%b required 0 0 1", bus.Cmd_ready, bus.Start, bus.Resp_valid);
        end
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL same_edge_data: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
        sb.push_back('{d: 16'h0000, c: 2'b00, chk_d: 1'b1});
        send(2'b00, 8'h7E, 16'hBEEF);
        total++;
        if (bus.Start !== 1'b1 || bus.Pointer !== 8'h7E || bus.Wdata_msb !== 8'hBE || bus.Wdata_lsb !== 8'hEF) begin
            bad++; $display("FAIL b2b_launch: Start=%b Pointer=%h msb=%h lsb=%h required 1 7e be ef", bus.Start, bus.Pointer, bus.Wdata_msb, bus.Wdata_lsb);
        end
        bus.Ready = 1'b0;
        tick(2);
        bus.Ready = 1'b1;
        tick();
        recv(d, c);
        e = sb.pop_front();
        total++;
        if (c !== e.c || (e.chk_d && d !== e.d)) begin bad++; $display("FAIL b2b_write_resp: code=%b data=%h required code=%b data=%h", c, d, e.c, e.d); end
    endtask

    initial begin
        bus.Cmd_valid = 1'b0;
        bus.Cmd_op = 2'b00;
        bus.Cmd_ptr = 8'h00;
        bus.Cmd_wdata = 16'h0000;
        bus.Resp_ready = 1'b0;
        bus.Ready = 1'b1;
        bus.Repeat = 1'b0;
        bus.Data_valid = 1'b0;
        bus.Error = 1'b0;
        bus.Data_rd = 8'h00;
        test_reset();
        test_write();
        test_ptr_read();
        test_one_byte();
        test_nack();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 required finish");
        $fatal(1);
    end
endmodule
